// File: rtl/my_3d4d_enc.sv
// 3b/4b running-disparity encoder driving the bits/cdr/flag symbol interface.
// One symbol per accepted word; flag is high HALF cycles then low HALF cycles.
module my_3d4d_enc #(
   parameter int unsigned HALF  = 2,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [3:0]       bits,
   output logic             cdr,
   output logic             flag,
   output logic             busy,
   output logic [CNT_W-1:0] sym_count
);

   localparam int unsigned PW = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [PW-1:0] LAST = PW'(HALF - 1);

   typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

   state_e           state_q, state_d;
   logic [PW-1:0]    cnt_q, cnt_d;
   logic             rd_q;
   logic [3:0]       bits_q;
   logic             cdr_q;
   logic [CNT_W-1:0] sym_q;

   logic       last;
   logic       accept;
   logic [3:0] code;
   logic       rd_nxt;

   assign last     = (cnt_q == LAST);
   assign in_ready = rst_n && ((state_q == StIdle) || ((state_q == StLow) && last));
   assign accept   = in_valid && in_ready;

   // Unbalanced codes alternate polarity so the line stays DC-balanced.
   always_comb begin
      code   = 4'b0000;
      rd_nxt = rd_q;
      unique case ({rd_q, in_data})
         4'b0_000: begin code = 4'b1011; rd_nxt = 1'b1; end
         4'b0_001: code = 4'b1001;
         4'b0_010: code = 4'b0101;
         4'b0_011: code = 4'b1100;
         4'b0_100: begin code = 4'b1101; rd_nxt = 1'b1; end
         4'b0_101: code = 4'b1010;
         4'b0_110: code = 4'b0110;
         4'b0_111: begin code = 4'b0111; rd_nxt = 1'b1; end
         4'b1_000: begin code = 4'b0100; rd_nxt = 1'b0; end
         4'b1_001: code = 4'b1001;
         4'b1_010: code = 4'b0101;
         4'b1_011: code = 4'b0011;
         4'b1_100: begin code = 4'b0010; rd_nxt = 1'b0; end
         4'b1_101: code = 4'b1010;
         4'b1_110: code = 4'b0110;
         4'b1_111: begin code = 4'b1000; rd_nxt = 1'b0; end
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StHigh;
               cnt_d   = '0;
            end
         end
         StHigh: begin
            if (last) begin
               state_d = StLow;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + PW'(1);
            end
         end
         StLow: begin
            if (last) begin
               state_d = accept ? StHigh : StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + PW'(1);
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         rd_q    <= 1'b0;
         bits_q  <= 4'b0000;
         cdr_q   <= 1'b0;
         sym_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            bits_q <= code;
            cdr_q  <= rd_q;
            rd_q   <= rd_nxt;
            sym_q  <= sym_q + CNT_W'(1);
         end
      end
   end

   assign bits      = bits_q;
   assign cdr       = cdr_q;
   assign flag      = (state_q == StHigh);
   assign busy      = (state_q != StIdle);
   assign sym_count = sym_q;

endmodule

// File: tb/tb_my_3d4d_enc.sv
// Bench for my_3d4d_enc: directed plan steps plus random traffic, checked
// against a table/weight-based encoder model and a flag-falling-edge decoder model.
module tb_my_3d4d_enc;

   localparam int unsigned H  = 2;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [2:0]    in_data = 3'b000;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [3:0]    bits;
   logic          cdr;
   logic          flag;
   logic          busy;
   logic [CW-1:0] sym_count;

   int          n_checks = 0;
   int          n_fail = 0;
   logic        m_rd = 1'b0;
   int unsigned m_cnt = 0;
   logic [3:0]  m_bits = 4'b0000;
   logic        m_cdr = 1'b0;

   my_3d4d_enc #(.HALF(H), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bits      (bits),
      .cdr       (cdr),
      .flag      (flag),
      .busy      (busy),
      .sym_count (sym_count)
   );

   always #5 clk = ~clk;

   // Primary table for rd=0; with rd=1 the unbalanced words and 011 use the complement.
   function automatic logic [3:0] ref_code(input logic rd, input logic [2:0] d);
      logic [31:0] tbl;
      logic [3:0]  p;
      tbl = {4'b0111, 4'b0110, 4'b1010, 4'b1101, 4'b1100, 4'b0101, 4'b1001, 4'b1011};
      p = tbl[d*4 +: 4];
      if (rd && (d == 3'd0 || d == 3'd3 || d == 3'd4 || d == 3'd7)) p = ~p;
      return p;
   endfunction

   function automatic logic ref_rd(input logic rd, input logic [3:0] c);
      if ($countones(c) == 3) return 1'b1;
      if ($countones(c) == 1) return 1'b0;
      return rd;
   endfunction

   function automatic int decode(input logic [3:0] b, input logic c);
      for (int e = 0; e < 8; e++) begin
         if (ref_code(c, 3'(e)) == b) return e;
      end
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_bits", 32'(bits), 32'h0);
      chk("rst_cdr", 32'(cdr), 32'h0);
      chk("rst_flag", 32'(flag), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_count", 32'(sym_count), 32'h0);
      chk("rst_ready", 32'(in_ready), 32'h0);
   endtask

   // Called #1 after an edge where the DUT must be ready; returns at the last
   // LOW sample of the symbol (ready again) with in_valid low.
   task automatic xfer(input logic [2:0] d);
      chk("ready_on_entry", 32'(in_ready), 32'h1);
      if (in_ready !== 1'b1) begin
         in_valid = 1'b0;
         @(posedge clk); #1;
         return;
      end
      in_valid = 1'b1;
      in_data  = d;
      m_bits = ref_code(m_rd, d);
      m_cdr  = m_rd;
      m_rd   = ref_rd(m_rd, m_bits);
      m_cnt  = (m_cnt + 1) % (1 << CW);
      @(posedge clk); #1;
      chk("sym_count", 32'(sym_count), 32'(m_cnt));
      for (int k = 0; k < 2*H; k++) begin
         chk("flag", 32'(flag), 32'(k < H));
         chk("in_ready", 32'(in_ready), 32'(k == 2*H-1));
         chk("busy", 32'(busy), 32'h1);
         chk("bits", 32'(bits), 32'(m_bits));
         chk("cdr", 32'(cdr), 32'(m_cdr));
         if (k == H) chk("loopback", 32'(decode(bits, cdr)), 32'(d));
         if (k < 2*H-1) begin
            in_valid = 1'($urandom % 2);
            in_data  = 3'($urandom);
            @(posedge clk); #1;
         end else begin
            in_valid = 1'b0;
         end
      end
   endtask

   task automatic idle_cycle();
      in_valid = 1'b0;
      in_data  = 3'($urandom);
      @(posedge clk); #1;
      chk("idle_busy", 32'(busy), 32'h0);
      chk("idle_flag", 32'(flag), 32'h0);
      chk("idle_bits", 32'(bits), 32'(m_bits));
      chk("idle_cdr", 32'(cdr), 32'(m_cdr));
      chk("idle_ready", 32'(in_ready), 32'h1);
   endtask

   initial begin
      // Reset wins over a valid word presented during reset.
      in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs();
      rst_n = 1'b1;
      in_valid = 1'b0;
      #1;
      chk("ready_after_rst", 32'(in_ready), 32'h1);

      xfer(3'b000);
      chk("first_bits", 32'(bits), 32'hB);
      xfer(3'b000);
      chk("second_bits", 32'(bits), 32'h4);
      chk("second_cdr", 32'(cdr), 32'h1);
      xfer(3'b011);
      xfer(3'b011);
      chk("neutral_bits", 32'(bits), 32'hC);
      xfer(3'b111);
      chk("w7_bits", 32'(bits), 32'h7);
      xfer(3'b011);
      chk("w3_rd1_bits", 32'(bits), 32'h3);
      chk("w3_rd1_cdr", 32'(cdr), 32'h1);

      // Every word from both disparities; 000 always flips disparity.
      for (int r = 0; r < 2; r++) begin
         for (int d = 0; d < 8; d++) begin
            if (m_rd != 1'(r)) xfer(3'b000);
            xfer(3'(d));
         end
      end

      // Idle gap, then a word three cycles later is taken at once.
      repeat (3) idle_cycle();
      xfer(3'b110);
      repeat (2) idle_cycle();

      // Abort mid-HIGH with rd left at 1, valid held through reset.
      in_data  = (m_rd == 1'b0) ? 3'b000 : 3'b101;
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("abort_flag_high", 32'(flag), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("rst_forces_ready", 32'(in_ready), 32'h0);
      repeat (2) begin
         @(posedge clk); #1;
         chk_reset_outputs();
      end
      rst_n = 1'b1;
      in_valid = 1'b0;
      m_rd = 1'b0; m_cnt = 0; m_bits = 4'b0000; m_cdr = 1'b0;
      #1;
      xfer(3'b000);
      chk("post_rst_bits", 32'(bits), 32'hB);
      chk("post_rst_cdr", 32'(cdr), 32'h0);

      // Random traffic with random idle gaps; the 4-bit counter wraps.
      for (int i = 0; i < 150; i++) begin
         xfer(3'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) idle_cycle();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
